ctl_flock: RTL and testbench
============================

# ctl_flock

Parametrised multi-duck flight controller; the N-duck successor to the single-duck `ctl_duck` in the game control section. It runs one state machine per duck slot and staggers spawns from the shared random number generator outputs. It resolves trigger hits to exactly one duck per shot and emits score, escape and round-complete events for `ctl_score` and the round logic. Its packed position and flag outputs feed the per-duck hit detectors and a multi-sprite `draw_duck`.

## Interface
Parameters:
- N_DUCKS, 2 — duck slots, 1..8
- H_SPEED, 10 — horizontal pixels per frame
- FALL_SPEED, 8 — downward pixels per frame while falling
- X_MAX, 960 — rightmost duck x (1024 − sprite width 64)
- Y_START, 600 — spawn y
- Y_GROUND, 700 — y at which a falling duck is removed
- SPAWN_GAP, 30 — frames between consecutive duck spawns

Ports:
- clk  in  1  65 MHz pixel clock
- rst  in  1  reset, asynchronous, active-high
- new_frame  in  1  one-cycle pulse per VGA frame
- game_start  in  1  one-cycle pulse; (re)starts a round
- pause  in  1  level; freezes all motion and counters
- shot_fired  in  1  one-cycle pulse from `ctl_trigger`
- hit_mask  in  N_DUCKS  per-duck target hit flags, valid with shot_fired
- rnd_direction  in  1  random start direction, 1 = right
- rnd_start_x  in  10  random start x
- rnd_v_spd  in  5  random vertical speed
- duck_x  out  10·N_DUCKS  packed x, duck i at [10i+9:10i]
- duck_y  out  10·N_DUCKS  packed y
- duck_show  out  N_DUCKS  duck i is visible (FLY or FALL)
- duck_hit  out  N_DUCKS  duck i is in FALL
- direction  out  N_DUCKS  1 = moving right
- score_inc  out  1  one-cycle pulse per accepted hit
- escaped  out  1  one-cycle pulse per escaped duck
- round_done  out  1  one-cycle pulse when the last live duck reaches GONE

## Operation
- Per-slot states: GONE, WAIT, FLY, FALL. Each slot also holds x[9:0], y[9:0], dir, v_spd[4:0], and wait_cnt sized for (N_DUCKS−1)·SPAWN_GAP.
- game_start: every slot goes to WAIT with wait_cnt = i·SPAWN_GAP. game_start has priority over every other event in the same cycle.
- Nothing in the next five rules happens while pause = 1.
- WAIT: on new_frame with wait_cnt ≠ 0, decrement. At most one spawn per new_frame: the lowest-index WAIT slot with wait_cnt = 0 loads x = min(rnd_start_x, X_MAX), y = Y_START, dir = rnd_direction, v_spd = max(rnd_v_spd, 1), and goes to FLY. Other zero-count slots spawn on later frames.
- FLY, on new_frame:
  - Moving right: if x + H_SPEED ≥ X_MAX then x = X_MAX and dir = 0; else x += H_SPEED.
  - Moving left: if x < H_SPEED then x = 0 and dir = 1; else x −= H_SPEED.
  - Vertical: if y ≤ v_spd, go to GONE and pulse escaped; else y −= v_spd.
  - Compute sums in 11 bits; no wrap-around.
- Hit: on a shot_fired cycle, candidates are slots with hit_mask[i] = 1 and state FLY. The lowest-index candidate goes to FALL and score_inc pulses. Other candidates are unaffected. shot_fired with no candidate does nothing.
- FALL, on new_frame: x is frozen. If y + FALL_SPEED ≥ Y_GROUND, go to GONE with no escaped pulse; else y += FALL_SPEED.
- If hit and new_frame land in the same cycle for a FLY slot, the hit wins: the slot enters FALL and its position is not updated that frame.
- If two slots escape on the same frame, escaped pulses once. Escape counting downstream is per frame.
- round_done pulses when the registered "all slots GONE" goes 0 → 1, excluding the reset edge.

## Timing
- All outputs registered. State and positions change on the clock edge after the qualifying input cycle; score_inc, escaped and round_done are high during that following cycle only.
- Reset values: all slots GONE; duck_x = 0; duck_y = 0; duck_show = 0; duck_hit = 0; direction = all 1; score_inc = escaped = round_done = 0.
- Asynchronous reset mid-round clears everything immediately. No spawn occurs until the next game_start.
- pause held: outputs are constant and shot_fired is ignored. Motion resumes on the first new_frame after pause falls.

## Test plan
- Spawn stagger: N_DUCKS = 2, SPAWN_GAP = 3, game_start, rnd_start_x = 100, rnd_direction = 1, rnd_v_spd = 4 -> duck 0 spawns on frame 1 and duck 1 on frame 4. Both load x = 100, y = 600, with duck_show rising one cycle after the spawning new_frame.
- Bounce: duck at x = 955 moving right, new_frame -> x = 960, direction = 0. Duck at x = 5 moving left, new_frame -> x = 0, direction = 1.
- Overlapping hit: both ducks FLY, shot_fired with hit_mask = 2'b11 -> only duck 0 enters FALL, one score_inc pulse, duck 1 stays FLY.
- Fall and round end: duck 1 hit at y = 690 -> after 2 frames it is GONE with escaped = 0. When it is the last live duck, round_done pulses exactly once.
- Escape: duck at y = 3, v_spd = 4, new_frame -> GONE, one escaped pulse, duck_show = 0 the next cycle.
- Pause and priority: pause high across 5 new_frames -> all outputs unchanged. game_start in the same cycle as shot_fired -> all slots go to WAIT and score_inc stays 0.

Source files
------------

// File: rtl/ctl_flock.sv
// Multi-duck flight controller: per-slot GONE/WAIT/FLY/FALL machines, staggered spawns, one hit per shot.
// One-cycle registered latency on all outputs; no backpressure, pause freezes all motion and hits.
module ctl_flock #(
   parameter int N_DUCKS    = 2,
   parameter int H_SPEED    = 10,
   parameter int FALL_SPEED = 8,
   parameter int X_MAX      = 960,
   parameter int Y_START    = 600,
   parameter int Y_GROUND   = 700,
   parameter int SPAWN_GAP  = 30
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    new_frame,
   input  logic                    game_start,
   input  logic                    pause,
   input  logic                    shot_fired,
   input  logic [N_DUCKS-1:0]      hit_mask,
   input  logic                    rnd_direction,
   input  logic [9:0]              rnd_start_x,
   input  logic [4:0]              rnd_v_spd,
   output logic [10*N_DUCKS-1:0]   duck_x,
   output logic [10*N_DUCKS-1:0]   duck_y,
   output logic [N_DUCKS-1:0]      duck_show,
   output logic [N_DUCKS-1:0]      duck_hit,
   output logic [N_DUCKS-1:0]      direction,
   output logic                    score_inc,
   output logic                    escaped,
   output logic                    round_done
);
   localparam int WMAX = (N_DUCKS - 1) * SPAWN_GAP;
   localparam int CW   = (WMAX < 2) ? 1 : $clog2(WMAX + 1);
   localparam logic [10:0] L_HS   = 11'(H_SPEED);
   localparam logic [10:0] L_FS   = 11'(FALL_SPEED);
   localparam logic [10:0] L_XMAX = 11'(X_MAX);
   localparam logic [10:0] L_YS   = 11'(Y_START);
   localparam logic [10:0] L_YG   = 11'(Y_GROUND);

   typedef enum logic [1:0] {S_GONE, S_WAIT, S_FLY, S_FALL} st_t;

   st_t             r_st  [N_DUCKS];
   st_t             w_st  [N_DUCKS];
   logic [9:0]      r_x   [N_DUCKS];
   logic [9:0]      w_x   [N_DUCKS];
   logic [9:0]      r_y   [N_DUCKS];
   logic [9:0]      w_y   [N_DUCKS];
   logic [4:0]      r_v   [N_DUCKS];
   logic [4:0]      w_v   [N_DUCKS];
   logic [CW-1:0]   r_cnt [N_DUCKS];
   logic [CW-1:0]   w_cnt [N_DUCKS];
   logic [N_DUCKS-1:0] r_dir, w_dir, r_show, r_hit;
   logic            r_score, r_esc, r_done;
   logic            w_score, w_esc, w_spawned, w_shot;
   logic            w_gone_now, w_gone_nxt;
   logic [10:0]     w_sum;

   always_comb begin
      w_st      = r_st;
      w_x       = r_x;
      w_y       = r_y;
      w_v       = r_v;
      w_cnt     = r_cnt;
      w_dir     = r_dir;
      w_score   = 1'b0;
      w_esc     = 1'b0;
      w_spawned = 1'b0;
      w_shot    = 1'b0;
      w_sum     = '0;
      if (game_start) begin
         for (int i = 0; i < N_DUCKS; i++) begin
            w_st[i]  = S_WAIT;
            w_cnt[i] = CW'(i * SPAWN_GAP);
         end
      end else if (!pause) begin
         for (int i = 0; i < N_DUCKS; i++) begin
            case (r_st[i])
               S_WAIT: if (new_frame) begin
                  if (r_cnt[i] != '0) begin
                     w_cnt[i] = r_cnt[i] - CW'(1);
                  end else if (!w_spawned) begin
                     w_spawned = 1'b1;
                     w_st[i]   = S_FLY;
                     w_x[i]    = ({1'b0, rnd_start_x} > L_XMAX) ? L_XMAX[9:0] : rnd_start_x;
                     w_y[i]    = L_YS[9:0];
                     w_dir[i]  = rnd_direction;
                     w_v[i]    = (rnd_v_spd == 5'd0) ? 5'd1 : rnd_v_spd;
                  end
               end
               S_FLY: begin
                  // The hit takes the slot out of FLY before this frame's motion applies.
                  if (shot_fired && hit_mask[i] && !w_shot) begin
                     w_shot   = 1'b1;
                     w_score  = 1'b1;
                     w_st[i]  = S_FALL;
                  end else if (new_frame) begin
                     if (r_dir[i]) begin
                        w_sum = {1'b0, r_x[i]} + L_HS;
                        if (w_sum >= L_XMAX) begin
                           w_x[i]   = L_XMAX[9:0];
                           w_dir[i] = 1'b0;
                        end else begin
                           w_x[i] = w_sum[9:0];
                        end
                     end else if ({1'b0, r_x[i]} < L_HS) begin
                        w_x[i]   = 10'd0;
                        w_dir[i] = 1'b1;
                     end else begin
                        w_x[i] = r_x[i] - L_HS[9:0];
                     end
                     if (r_y[i] <= {5'b0, r_v[i]}) begin
                        w_st[i] = S_GONE;
                        w_esc   = 1'b1;
                     end else begin
                        w_y[i] = r_y[i] - {5'b0, r_v[i]};
                     end
                  end
               end
               S_FALL: if (new_frame) begin
                  w_sum = {1'b0, r_y[i]} + L_FS;
                  if (w_sum >= L_YG) begin
                     w_st[i] = S_GONE;
                  end else begin
                     w_y[i] = w_sum[9:0];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      w_gone_now = 1'b1;
      w_gone_nxt = 1'b1;
      for (int i = 0; i < N_DUCKS; i++) begin
         if (r_st[i] != S_GONE) w_gone_now = 1'b0;
         if (w_st[i] != S_GONE) w_gone_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_DUCKS; i++) begin
            r_st[i]  <= S_GONE;
            r_x[i]   <= '0;
            r_y[i]   <= '0;
            r_v[i]   <= '0;
            r_cnt[i] <= '0;
         end
         r_dir   <= '1;
         r_show  <= '0;
         r_hit   <= '0;
         r_score <= 1'b0;
         r_esc   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_st  <= w_st;
         r_x   <= w_x;
         r_y   <= w_y;
         r_v   <= w_v;
         r_cnt <= w_cnt;
         r_dir <= w_dir;
         for (int i = 0; i < N_DUCKS; i++) begin
            r_show[i] <= (w_st[i] == S_FLY) || (w_st[i] == S_FALL);
            r_hit[i]  <= (w_st[i] == S_FALL);
         end
         r_score <= w_score;
         r_esc   <= w_esc;
         r_done  <= w_gone_nxt && !w_gone_now;
      end
   end

   for (genvar g = 0; g < N_DUCKS; g++) begin : g_pack
      assign duck_x[10*g +: 10] = r_x[g];
      assign duck_y[10*g +: 10] = r_y[g];
   end

   assign duck_show  = r_show;
   assign duck_hit   = r_hit;
   assign direction  = r_dir;
   assign score_inc  = r_score;
   assign escaped    = r_esc;
   assign round_done = r_done;
endmodule

// File: tb/tb_ctl_flock.sv
// Directed bench for ctl_flock (2 ducks, spawn gap 3): expectations queued per step, checked after it.
module tb_ctl_flock;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       new_frame = 1'b0, game_start = 1'b0, pause = 1'b0, shot_fired = 1'b0;
   logic [1:0] hit_mask = 2'b00;
   logic       rnd_direction = 1'b0;
   logic [9:0] rnd_start_x = 10'd0;
   logic [4:0] rnd_v_spd = 5'd0;
   logic [19:0] duck_x, duck_y;
   logic [1:0]  duck_show, duck_hit, direction;
   logic        score_inc, escaped, round_done;
   int n_tests = 0;
   int n_fail  = 0;

   typedef enum {F_X, F_Y, F_SHOW, F_HIT, F_DIR, F_SCORE, F_ESC, F_DONE} fld_t;
   typedef struct {
      string       tag;
      fld_t        f;
      int          d;
      logic [31:0] v;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   ctl_flock #(.N_DUCKS(2), .SPAWN_GAP(3)) dut (
      .clk(clk), .rst(rst), .new_frame(new_frame), .game_start(game_start), .pause(pause),
      .shot_fired(shot_fired), .hit_mask(hit_mask), .rnd_direction(rnd_direction),
      .rnd_start_x(rnd_start_x), .rnd_v_spd(rnd_v_spd), .duck_x(duck_x), .duck_y(duck_y),
      .duck_show(duck_show), .duck_hit(duck_hit), .direction(direction),
      .score_inc(score_inc), .escaped(escaped), .round_done(round_done)
   );

   function automatic logic [31:0] obs(fld_t f, int d);
      case (f)
         F_X:     return 32'(duck_x[10*d +: 10]);
         F_Y:     return 32'(duck_y[10*d +: 10]);
         F_SHOW:  return 32'(duck_show[d]);
         F_HIT:   return 32'(duck_hit[d]);
         F_DIR:   return 32'(direction[d]);
         F_SCORE: return 32'(score_inc);
         F_ESC:   return 32'(escaped);
         default: return 32'(round_done);
      endcase
   endfunction

   task automatic push(input string tag, input fld_t f, input int d, input int v);
      exp_t e;
      e.tag = tag; e.f = f; e.d = d; e.v = 32'(v);
      sb.push_back(e);
   endtask

   task automatic push_duck(input string tag, input int d, input int x, input int y,
                            input int show, input int hit, input int dir);
      push(tag, F_X, d, x);
      push(tag, F_Y, d, y);
      push(tag, F_SHOW, d, show);
      push(tag, F_HIT, d, hit);
      push(tag, F_DIR, d, dir);
   endtask

   task automatic check();
      exp_t        e;
      logic [31:0] o;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs(e.f, e.d);
         n_tests++;
         assert (o === e.v) else begin
            n_fail++;
            $error("FAIL %s %s[%0d]: observed %0d expected %0d", e.tag, e.f.name(), e.d, o, e.v);
         end
      end
   endtask

   task automatic step(input logic nf, input logic gs, input logic sf, input logic [1:0] hm);
      @(negedge clk);
      new_frame = nf; game_start = gs; shot_fired = sf; hit_mask = hm;
      @(negedge clk);
      new_frame = 1'b0; game_start = 1'b0; shot_fired = 1'b0; hit_mask = 2'b00;
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 2'b00);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      push_duck("reset", 0, 0, 0, 0, 0, 1);
      push_duck("reset", 1, 0, 0, 0, 0, 1);
      push("reset", F_SCORE, 0, 0); push("reset", F_ESC, 0, 0); push("reset", F_DONE, 0, 0);
      check();
      rst = 1'b0;
      step(0, 0, 0, 2'b00);
      push("post_reset_done", F_DONE, 0, 0);
      check();

      // Round A: stagger, overlapping hit, fall to ground, round end
      rnd_start_x = 10'd100; rnd_direction = 1'b1; rnd_v_spd = 5'd4;
      step(0, 1, 0, 2'b00);
      push("start", F_SHOW, 0, 0); push("start", F_SHOW, 1, 0); push("start", F_DONE, 0, 0);
      check();
      frames(1);
      push_duck("spawn0", 0, 100, 600, 1, 0, 1); push("spawn0", F_SHOW, 1, 0);
      check();
      frames(1);
      push("fly_f2", F_X, 0, 110); push("fly_f2", F_Y, 0, 596); push("stagger_f2", F_SHOW, 1, 0);
      check();
      frames(1);
      push("fly_f3", F_X, 0, 120); push("fly_f3", F_Y, 0, 592); push("stagger_f3", F_SHOW, 1, 0);
      check();
      frames(1);
      push_duck("spawn1", 1, 100, 600, 1, 0, 1); push("fly_f4", F_X, 0, 130); push("fly_f4", F_Y, 0, 588);
      check();
      step(1, 0, 1, 2'b11);
      push_duck("hit_both", 0, 130, 588, 1, 1, 1);
      push_duck("hit_both", 1, 110, 596, 1, 0, 1);
      push("hit_both", F_SCORE, 0, 1);
      check();
      step(0, 0, 0, 2'b00);
      push("score_once", F_SCORE, 0, 0);
      check();
      frames(13);
      push("fall13", F_X, 0, 130); push("fall13", F_Y, 0, 692); push("fall13", F_SHOW, 0, 1);
      check();
      frames(1);
      push("ground0", F_SHOW, 0, 0); push("ground0", F_HIT, 0, 0);
      push("ground0", F_ESC, 0, 0); push("ground0", F_DONE, 0, 0);
      push("fly1", F_X, 1, 250); push("fly1", F_Y, 1, 540);
      check();
      step(0, 0, 1, 2'b11);
      push("hit_last", F_HIT, 1, 1); push("hit_last", F_SCORE, 0, 1);
      check();
      frames(19);
      push("fall19", F_Y, 1, 692); push("fall19", F_X, 1, 250); push("fall19", F_DONE, 0, 0);
      check();
      frames(1);
      push("ground1", F_SHOW, 1, 0); push("ground1", F_ESC, 0, 0); push("ground1", F_DONE, 0, 1);
      check();
      step(0, 0, 0, 2'b00);
      push("done_once", F_DONE, 0, 0);
      check();

      // Round B: wall bounces, pause, escapes at y == v_spd
      rnd_start_x = 10'd955; rnd_direction = 1'b1; rnd_v_spd = 5'd30;
      step(0, 1, 0, 2'b00);
      frames(1);
      push_duck("spawn955", 0, 955, 600, 1, 0, 1);
      check();
      frames(1);
      push_duck("bounce_r", 0, 960, 570, 1, 0, 0);
      check();
      frames(1);
      rnd_start_x = 10'd5; rnd_direction = 1'b0;
      frames(1);
      push_duck("spawn5", 1, 5, 600, 1, 0, 0);
      check();
      frames(1);
      push_duck("bounce_l", 1, 0, 570, 1, 0, 1);
      check();
      frames(1);
      push_duck("f6", 0, 920, 450, 1, 0, 0);
      push_duck("f6", 1, 10, 540, 1, 0, 1);
      check();
      pause = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step(1, 0, (k == 2), 2'b11);
         push_duck("pause", 0, 920, 450, 1, 0, 0);
         push_duck("pause", 1, 10, 540, 1, 0, 1);
         push("pause", F_SCORE, 0, 0);
         check();
      end
      pause = 1'b0;
      frames(14);
      push_duck("f20", 0, 780, 30, 1, 0, 0);
      check();
      frames(1);
      push("escape0", F_SHOW, 0, 0); push("escape0", F_ESC, 0, 1); push("escape0", F_DONE, 0, 0);
      check();
      frames(1);
      push("esc_once", F_ESC, 0, 0);
      check();
      frames(1);
      push_duck("f23", 1, 180, 30, 1, 0, 1);
      check();
      frames(1);
      push("escape1", F_SHOW, 1, 0); push("escape1", F_ESC, 0, 1); push("escape1", F_DONE, 0, 1);
      check();
      step(0, 0, 0, 2'b00);
      push("after_b", F_ESC, 0, 0); push("after_b", F_DONE, 0, 0);
      check();

      // Round C: spawn clamps, game_start beats shot_fired
      rnd_start_x = 10'd1000; rnd_direction = 1'b1; rnd_v_spd = 5'd0;
      step(0, 1, 0, 2'b00);
      frames(1);
      push_duck("clamp", 0, 960, 600, 1, 0, 1);
      check();
      frames(1);
      push_duck("vmin", 0, 960, 599, 1, 0, 0);
      check();
      step(0, 1, 1, 2'b11);
      push("gs_vs_shot", F_SHOW, 0, 0); push("gs_vs_shot", F_HIT, 0, 0); push("gs_vs_shot", F_SCORE, 0, 0);
      check();
      step(0, 0, 0, 2'b00);
      push("gs_no_score", F_SCORE, 0, 0);
      check();
      frames(1);
      push_duck("respawn", 0, 960, 600, 1, 0, 1);
      check();

      // Asynchronous reset mid-round
      @(negedge clk);
      rst = 1'b1;
      #1;
      push_duck("async_rst", 0, 0, 0, 0, 0, 1);
      check();
      @(negedge clk);
      rst = 1'b0;
      frames(5);
      push("no_spawn", F_SHOW, 0, 0); push("no_spawn", F_SHOW, 1, 0); push("no_spawn", F_DONE, 0, 0);
      check();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
